word_catcher: RTL and testbench



---
 rtl/word_catcher_pkg.sv | 17 +
 rtl/cereal_rx.sv | 113 +++++++++++
 rtl/word_catcher.sv | 84 ++++++++
 tb/tb_word_catcher.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/word_catcher_pkg.sv
// Shared definitions for the word_catcher serial receiver: RX FSM encoding,
// default timing parameters and the word length ceiling.
package word_catcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 10417;
  localparam int GAP_CLKS_DEF     = 200000;
  localparam int WORD_LEN_MAX     = 63;

endpackage

// File: rtl/cereal_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle
// char_valid / frame_err pulses registered one cycle after the stop sample.
module cereal_rx
  import word_catcher_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] char_data,
  output logic       char_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       start_det,
  output logic [2:0] rx_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state_q, state_d;
  logic             sync1, rxs;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             load_half, load_full, shift_en, good_stop, bad_stop;
  logic             cnt_zero;

  assign cnt_zero  = (cnt_q == '0);
  assign start_det = (state_q == ST_IDLE) && !rxs;
  assign busy      = (state_q != ST_IDLE);
  assign rx_state  = state_q;

  always_comb begin
    state_d   = state_q;
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d   = ST_START;
          load_half = 1'b1;
        end
      end
      ST_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_zero) begin
          if (!rxs) begin
            state_d   = ST_DATA;
            load_full = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_zero) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_zero) begin
          if (rxs) begin
            good_stop = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      char_data  <= 8'h00;
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1      <= rx;
      rxs        <= sync1;
      char_valid <= good_stop;
      frame_err  <= bad_stop;
      if (load_half)      cnt_q <= HALF_M1;
      else if (load_full) cnt_q <= FULL_M1;
      else if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
      if (state_q == ST_START) bit_q <= 3'd0;
      else if (shift_en)       bit_q <= bit_q + 3'd1;
      if (shift_en)  shift_q   <= {rxs, shift_q[7:1]};
      if (good_stop) char_data <= shift_q;
    end
  end

endmodule

// File: rtl/word_catcher.sv
// Groups received characters into words separated by idle gaps and reports
// each closed word's length, mod-256 checksum and overflow flag.
module word_catcher
  import word_catcher_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int GAP_CLKS     = GAP_CLKS_DEF,
  parameter int GAP_W        = 18
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] char_data,
  output logic       char_valid,
  output logic       frame_err,
  output logic       word_done,
  output logic [5:0] word_len,
  output logic [7:0] word_sum,
  output logic       word_ovf,
  output logic       busy
);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);
  localparam logic [5:0]       LEN_MAX  = 6'(WORD_LEN_MAX);

  logic             start_det;
  logic [2:0]       rx_state;
  logic [GAP_W-1:0] gap_q;
  logic [5:0]       len_acc;
  logic [7:0]       sum_acc;
  logic             ovf_acc;

  cereal_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .rx        (rx),
    .char_data (char_data),
    .char_valid(char_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .start_det (start_det),
    .rx_state  (rx_state)
  );

  // A start bit seen on the closing cycle wins: the word stays open.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q     <= '0;
      len_acc   <= 6'd0;
      sum_acc   <= 8'h00;
      ovf_acc   <= 1'b0;
      word_done <= 1'b0;
      word_len  <= 6'd0;
      word_sum  <= 8'h00;
      word_ovf  <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (char_valid) begin
        if (len_acc != LEN_MAX) len_acc <= len_acc + 6'd1;
        else                    ovf_acc <= 1'b1;
        sum_acc <= sum_acc + char_data;
        gap_q   <= '0;
      end else if ((rx_state != ST_IDLE) || start_det) begin
        gap_q <= '0;
      end else if (len_acc != 6'd0) begin
        if (gap_q == GAP_LAST) begin
          word_done <= 1'b1;
          word_len  <= len_acc;
          word_sum  <= sum_acc;
          word_ovf  <= ovf_acc;
          len_acc   <= 6'd0;
          sum_acc   <= 8'h00;
          ovf_acc   <= 1'b0;
          gap_q     <= '0;
        end else begin
          gap_q <= gap_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_word_catcher.sv
// Directed bench for word_catcher: serial stimulus with expected characters and
// words queued ahead of time and matched against DUT pulses on the falling edge.
module tb_word_catcher;

  localparam int CPB = 16;
  localparam int GAP = 400;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic       rx     = 1'b1;
  logic [7:0] char_data;
  logic       char_valid;
  logic       frame_err;
  logic       word_done;
  logic [5:0] word_len;
  logic [7:0] word_sum;
  logic       word_ovf;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_char_q[$];
  logic [14:0] exp_word_q[$];  // {ovf, len, sum}
  int          exp_ferr = 0;

  word_catcher #(
    .CLKS_PER_BIT(CPB),
    .GAP_CLKS    (GAP),
    .GAP_W       (18)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .rx        (rx),
    .char_data (char_data),
    .char_valid(char_valid),
    .frame_err (frame_err),
    .word_done (word_done),
    .word_len  (word_len),
    .word_sum  (word_sum),
    .word_ovf  (word_ovf),
    .busy      (busy)
  );

  initial forever #5 sysclk = ~sysclk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_char_data"}, 32'(char_data), 32'h00);
    check({tag, "_pulses"}, 32'({char_valid, frame_err, word_done}), 32'h0);
    check({tag, "_word"}, 32'({word_ovf, word_len, word_sum}), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_chars_left"}, 32'(exp_char_q.size()), 32'd0);
    check({tag, "_words_left"}, 32'(exp_word_q.size()), 32'd0);
    check({tag, "_ferr_left"}, 32'(exp_ferr), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = c[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  task automatic send_char(input logic [7:0] c);
    exp_char_q.push_back(c);
    send_frame(c, 1'b1);
  endtask

  // Scoreboard: every DUT pulse must match the head of its expected queue.
  always @(negedge sysclk) begin
    if (char_valid) begin
      logic       have;
      logic [7:0] e;
      have = (exp_char_q.size() > 0);
      e    = have ? exp_char_q.pop_front() : 8'h00;
      n_checks++;
      assert (have && (char_data === e)) else begin
        n_errors++;
        $error("FAIL char_valid got=%0h exp=%0h pending=%0d", char_data, e, have);
      end
    end
    if (word_done) begin
      logic        have;
      logic [14:0] e;
      have = (exp_word_q.size() > 0);
      e    = have ? exp_word_q.pop_front() : 15'h0;
      n_checks++;
      assert (have && ({word_ovf, word_len, word_sum} === e)) else begin
        n_errors++;
        $error("FAIL word_done got ovf=%0d len=%0d sum=%0h exp ovf=%0d len=%0d sum=%0h pending=%0d",
               word_ovf, word_len, word_sum, e[14], e[13:8], e[7:0], have);
      end
    end
    if (frame_err) begin
      n_checks++;
      assert (exp_ferr > 0) else begin
        n_errors++;
        $error("FAIL frame_err got=1 exp=0");
      end
      if (exp_ferr > 0) exp_ferr--;
    end
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(5);

    // Single character word
    exp_word_q.push_back({1'b0, 6'd1, 8'h48});
    send_char(8'h48);
    tick(500);
    check_drained("single");

    // HELLO back-to-back
    exp_word_q.push_back({1'b0, 6'd5, 8'h74});
    send_char(8'h48);
    send_char(8'h45);
    send_char(8'h4C);
    send_char(8'h4C);
    send_char(8'h4F);
    tick(500);
    check_drained("hello");

    // Framing error: busy held while the line stays low
    exp_ferr = 1;
    send_frame(8'h41, 1'b0);
    tick(40);
    check("ferr_busy_low", 32'(busy), 32'h1);
    check("ferr_seen", 32'(exp_ferr), 32'd0);
    rx = 1'b1;
    tick(5);
    check("ferr_busy_released", 32'(busy), 32'h0);

    // Short glitch then long idle: nothing at all
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    check("glitch_busy", 32'(busy), 32'h0);
    tick(500);
    check_drained("glitch");

    // Overflow then a fresh word
    exp_word_q.push_back({1'b1, 6'd63, 8'h41});
    for (int i = 0; i < 65; i++) send_char(8'h01);
    tick(500);
    check_drained("ovf");
    exp_word_q.push_back({1'b0, 6'd1, 8'h41});
    send_char(8'h41);
    tick(500);
    check_drained("after_ovf");

    // Gap boundary. char_valid follows the stop-bit end by -4 cycles and a
    // start bit reaches the detector 3 cycles after rx falls, so rx idle of
    // GAP-8 lands on gap count GAP-2 and GAP-7 on the closing count GAP-1.
    exp_word_q.push_back({1'b0, 6'd2, 8'h83});
    send_char(8'h41);
    tick(GAP - 8);
    send_char(8'h42);
    tick(500);
    check_drained("gap_minus2");

    exp_word_q.push_back({1'b0, 6'd2, 8'h83});
    send_char(8'h41);
    tick(GAP - 7);
    send_char(8'h42);
    tick(500);
    check_drained("gap_on_close");

    exp_word_q.push_back({1'b0, 6'd1, 8'h41});
    exp_word_q.push_back({1'b0, 6'd1, 8'h42});
    send_char(8'h41);
    tick(GAP - 6);
    send_char(8'h42);
    tick(500);
    check_drained("gap_closed");

    // Reset during the third character's data bits
    send_char(8'h41);
    send_char(8'h42);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    check("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check_drained("mid_reset");
    exp_word_q.push_back({1'b0, 6'd2, 8'h83});
    send_char(8'h41);
    send_char(8'h42);
    tick(500);
    check_drained("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
